// File: rtl/calc_mem_pkg.sv
// calc_mem_pkg: command codes, FSM states and digit type shared by the memory bank
package calc_mem_pkg;
  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_STORE     = 3'd1;
  localparam logic [2:0] CMD_RECALL    = 3'd2;
  localparam logic [2:0] CMD_CLEAR     = 3'd3;
  localparam logic [2:0] CMD_CLEAR_ALL = 3'd4;
  localparam logic [2:0] CMD_ADD       = 3'd5;
  localparam logic [2:0] CMD_SUB       = 3'd6;
  typedef enum logic [1:0] {S_IDLE, S_ARITH, S_WRITE} state_t;
  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit_addsub.sv
// bcd_digit_addsub: combinational single-digit BCD add (a+b+cin) or subtract (a-b-cin)
module bcd_digit_addsub
  import calc_mem_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
);
  logic [4:0] s, d;
  assign s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign d = {1'b0, a} - {1'b0, b} - {4'b0, cin};
  assign cout  = sub ? d[4] : (s > 5'd9);
  assign digit = sub ? (d[4] ? 4'(d + 5'd10) : d[3:0]) : (s > 5'd9 ? 4'(s - 5'd10) : s[3:0]);
endmodule

// File: rtl/calc_memory_bank.sv
// calc_memory_bank: BCD memory slots with store/recall/clear and digit-serial M+/M-; CALC_MEM_SATURATE_EN clamps overflow results
module calc_memory_bank
  import calc_mem_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int SLOTS  = 4,
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int W  = 4 * DIGITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [SW-1:0]    slot,
  input  logic [W-1:0]     display_digits,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [W-1:0]     recall_digits,
  output logic [SLOTS-1:0] mem_nonzero
);
  logic [W-1:0] mem [SLOTS];
  logic [W-1:0] op_c, a_q, b_q, res, wres;
  logic [IW-1:0] idx;
  logic [SW-1:0] slot_q;
  logic carry, sub_q, acc, slot_ok, arith_cmd, co;
  bcd_digit_t dg;
  state_t state, next;
  assign slot_ok   = {1'b0, slot} < (SW+1)'(SLOTS);
  assign acc       = cmd_valid && state == S_IDLE;
  assign arith_cmd = slot_ok && (cmd == CMD_ADD || cmd == CMD_SUB);
  assign busy      = state != S_IDLE;
`ifdef CALC_MEM_SATURATE_EN
  assign wres = carry ? (sub_q ? '0 : {DIGITS{4'h9}}) : res;
`else
  assign wres = res;
`endif
  bcd_digit_addsub u_addsub (
    .a(a_q[idx*4 +: 4]), .b(b_q[idx*4 +: 4]), .cin(carry), .sub(sub_q), .digit(dg), .cout(co)
  );
  // operand digits above 9 are clamped to 9
  always_comb begin
    op_c = '0;
    for (int d = 0; d < DIGITS; d++)
      op_c[d*4 +: 4] = display_digits[d*4 +: 4] > 4'd9 ? 4'd9 : display_digits[d*4 +: 4];
  end
  // "M" indicators reflect any non-zero slot
  always_comb begin
    mem_nonzero = '0;
    for (int i = 0; i < SLOTS; i++) mem_nonzero[i] = |mem[i];
  end
  // next-state: IDLE -> ARITH (one digit per cycle) -> WRITE -> IDLE
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = (acc && arith_cmd) ? S_ARITH : S_IDLE;
      S_ARITH: next = (idx == IW'(DIGITS-1)) ? S_WRITE : S_ARITH;
      default: next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next;
  // slot storage, command execution and serial arithmetic datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      {a_q, b_q, res, recall_digits} <= '0;
      {idx, slot_q, carry, sub_q, done, overflow} <= '0;
    end else begin
      done <= 1'b0;
      if (acc && cmd == CMD_CLEAR_ALL) begin
        for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
        done     <= 1'b1;
        overflow <= 1'b0;
      end else if (acc && slot_ok) begin
        case (cmd)
          CMD_STORE:  mem[slot] <= op_c;
          CMD_RECALL: recall_digits <= mem[slot];
          CMD_CLEAR:  mem[slot] <= '0;
          CMD_ADD, CMD_SUB: begin
            a_q    <= mem[slot];
            b_q    <= op_c;
            idx    <= '0;
            carry  <= 1'b0;
            sub_q  <= cmd == CMD_SUB;
            slot_q <= slot;
          end
          default: ;
        endcase
        if (cmd == CMD_STORE || cmd == CMD_RECALL || cmd == CMD_CLEAR) begin
          done     <= 1'b1;
          overflow <= 1'b0;
        end
      end
      if (state == S_ARITH) begin
        res[idx*4 +: 4] <= dg;
        carry <= co;
        idx   <= idx + 1'b1;
      end
      if (state == S_WRITE) begin
        mem[slot_q] <= wres;
        overflow    <= carry;
        done        <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_calc_memory_bank.sv
// tb_calc_memory_bank: table vectors, corner sequences and random ops against a decimal model
module tb_calc_memory_bank;
  logic clock = 0, reset = 1, cmd_valid = 0;
  logic [2:0] cmd = 0;
  logic [1:0] slot = 0;
  logic [11:0] display_digits = 0;
  logic busy, done, overflow;
  logic [11:0] recall_digits;
  logic [3:0] mem_nonzero;
  int n_cmp = 0, n_err = 0;
  int m[4];
  int ovf_m = 0, rec_m = 0;

  calc_memory_bank #(.DIGITS(3), .SLOTS(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .slot(slot),
    .display_digits(display_digits), .busy(busy), .done(done), .overflow(overflow),
    .recall_digits(recall_digits), .mem_nonzero(mem_nonzero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] c; logic [1:0] s; logic [11:0] v;
    logic d; logic [3:0] nz; logic [11:0] rc;
  } vec_t;
  vec_t tbl[11];

  function automatic int b2i(input logic [11:0] v);
    int r, x;
    r = 0;
    for (int d = 2; d >= 0; d--) begin
      x = int'(v[d*4 +: 4]);
      r = r * 10 + (x > 9 ? 9 : x);
    end
    return r;
  endfunction

  function automatic logic [11:0] i2b(input int n);
    logic [11:0] r;
    for (int d = 0; d < 3; d++) begin
      r[d*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] s, input logic [11:0] v);
    @(negedge clock);
    cmd_valid = 1; cmd = c; slot = s; display_digits = v;
    @(posedge clock);
    #1 cmd_valid = 0;
  endtask

  function automatic logic [3:0] nz_m();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m[i] != 0;
    return r;
  endfunction

  // apply one command, predict its effect from decimal arithmetic, check latency and outputs
  task automatic do_op(input logic [2:0] c, input logic [1:0] s, input logic [11:0] v);
    int o, r, lat, exp_lat;
    bit ev;
    o = b2i(v); ev = 1; exp_lat = 0;
    case (c)
      1: begin m[s] = o; ovf_m = 0; end
      2: begin rec_m = m[s]; ovf_m = 0; end
      3: begin m[s] = 0; ovf_m = 0; end
      4: begin for (int i = 0; i < 4; i++) m[i] = 0; ovf_m = 0; end
      5, 6: begin
        exp_lat = 4;
        r = (c == 5) ? m[s] + o : m[s] - o;
        ovf_m = (r > 999 || r < 0) ? 1 : 0;
`ifdef CALC_MEM_SATURATE_EN
        m[s] = r > 999 ? 999 : (r < 0 ? 0 : r);
`else
        m[s] = (r + 1000) % 1000;
`endif
      end
      default: ev = 0;
    endcase
    issue(c, s, v);
    check("busy_start", busy, (c == 5 || c == 6) ? 1 : 0);
    lat = 0;
    while (!done && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    if (ev) check("latency", lat, exp_lat);
    else check("nop_done", done, 0);
    check("busy_end", busy, 0);
    check("overflow", overflow, ovf_m);
    check("recall", recall_digits, i2b(rec_m));
    check("nonzero", mem_nonzero, nz_m());
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 4; i++) m[i] = 0;
    tbl[0]  = '{3'd1, 2'd2, 12'h123, 1'b1, 4'b0100, 12'h000};
    tbl[1]  = '{3'd2, 2'd2, 12'h000, 1'b1, 4'b0100, 12'h123};
    tbl[2]  = '{3'd1, 2'd0, 12'hA5F, 1'b1, 4'b0101, 12'h123};
    tbl[3]  = '{3'd2, 2'd0, 12'h000, 1'b1, 4'b0101, 12'h959};
    tbl[4]  = '{3'd0, 2'd1, 12'h111, 1'b0, 4'b0101, 12'h959};
    tbl[5]  = '{3'd7, 2'd1, 12'h222, 1'b0, 4'b0101, 12'h959};
    tbl[6]  = '{3'd3, 2'd2, 12'h000, 1'b1, 4'b0001, 12'h959};
    tbl[7]  = '{3'd1, 2'd1, 12'h000, 1'b1, 4'b0001, 12'h959};
    tbl[8]  = '{3'd1, 2'd3, 12'h050, 1'b1, 4'b1001, 12'h959};
    tbl[9]  = '{3'd4, 2'd1, 12'h000, 1'b1, 4'b0000, 12'h959};
    tbl[10] = '{3'd2, 2'd3, 12'h000, 1'b1, 4'b0000, 12'h000};
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_recall", recall_digits, 0);
    check("rst_nz", mem_nonzero, 0);
    // table-driven single-cycle commands
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].c, tbl[i].s, tbl[i].v);
      check("tbl_done", done, tbl[i].d);
      check("tbl_busy", busy, 0);
      check("tbl_nz", mem_nonzero, tbl[i].nz);
      check("tbl_recall", recall_digits, tbl[i].rc);
    end
    // ADD overflow: 001 + 999
    do_op(1, 0, 12'h001);
    do_op(5, 0, 12'h999);
    check("add_ovf", overflow, 1);
    do_op(2, 0, 12'h000);
`ifdef CALC_MEM_SATURATE_EN
    check("add_sat", recall_digits, 12'h999);
`else
    check("add_wrap", recall_digits, 12'h000);
`endif
    // SUB with and without borrow
    do_op(1, 1, 12'h123);
    do_op(6, 1, 12'h050);
    check("sub_ovf0", overflow, 0);
    do_op(2, 1, 12'h000);
    check("sub_073", recall_digits, 12'h073);
    do_op(6, 1, 12'h200);
    check("sub_ovf1", overflow, 1);
    do_op(2, 1, 12'h000);
`ifdef CALC_MEM_SATURATE_EN
    check("sub_sat", recall_digits, 12'h000);
`else
    check("sub_wrap", recall_digits, 12'h873);
`endif
    // STORE during busy is ignored, one done only
    do_op(1, 0, 12'h321);
    do_op(1, 3, 12'h010);
    issue(5, 3, 12'h005);
    @(negedge clock);
    cmd_valid = 1; cmd = 1; slot = 0; display_digits = 12'h777;
    @(posedge clock); #1 cmd_valid = 0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) dones++;
      @(posedge clock); #1;
    end
    check("busy_dones", dones, 1);
    m[3] = 15;
    do_op(2, 0, 12'h000);
    check("busy_slot0", recall_digits, 12'h321);
    do_op(2, 3, 12'h000);
    check("busy_slot3", recall_digits, 12'h015);
    // reset in the middle of an ADD
    do_op(1, 2, 12'h500);
    do_op(2, 2, 12'h000);
    do_op(5, 2, 12'h600);
    issue(5, 2, 12'h001);
    @(posedge clock);
    #2 reset = 1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_ovf", overflow, 0);
    check("mid_recall", recall_digits, 0);
    check("mid_nz", mem_nonzero, 0);
    @(negedge clock) reset = 0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    ovf_m = 0; rec_m = 0;
    do_op(1, 1, 12'h042);
    do_op(2, 1, 12'h000);
    check("post_rst", recall_digits, 12'h042);
    // random commands against the decimal model
    for (int k = 0; k < 60; k++)
      do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 12'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
